// File: rtl/edid_pkg.sv
// Shared types and constants for the EDID update controller and its ROM.
package edid_pkg;

    typedef enum logic [2:0] {
        DROP,
        COPY,
        FINISH,
        HOLD,
        READY
    } edid_state_t;

    localparam int EDID_LEN      = 128;
    localparam int IMG_1280_1024 = 0;
    localparam int IMG_1920_1080 = 1;

    localparam logic [7:0] RD_BUSY = 8'hFF;
    localparam logic [7:0] RD_OOR  = 8'h00;

endpackage

// File: rtl/edid_rom.sv
// Registered EDID image ROM addressed by {sel, addr}; data appears one cycle after the address.
// Unlisted image indices fall back to the 1280x1024 image.
module edid_rom
    import edid_pkg::*;
#(
    parameter int IMG_W = 1
) (
    input  logic             i_clk,
    input  logic [IMG_W-1:0] i_sel,
    input  logic [6:0]       i_addr,
    output logic [7:0]       o_data
);

    logic [7:0] r_data;

    function automatic logic [7:0] f_img_1280(input logic [6:0] a);
        logic [7:0] b;
        b = 8'h00;
        case (a)
            7'h01, 7'h02, 7'h03, 7'h04, 7'h05, 7'h06: b = 8'hFF;
            7'h08: b = 8'h10;
            7'h09: b = 8'hAC;
            7'h0A: b = 8'h02;
            7'h12: b = 8'h01;
            7'h13: b = 8'h03;
            7'h14: b = 8'h80;
            7'h15: b = 8'h22;
            7'h16: b = 8'h1B;
            7'h18: b = 8'hD4;
            7'h36: b = 8'h30;
            7'h37: b = 8'h2A;
            7'h3A: b = 8'h50;
            7'h3D: b = 8'h40;
            7'h7F: b = 8'hC9;
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    function automatic logic [7:0] f_img_1920(input logic [6:0] a);
        logic [7:0] b;
        b = 8'h00;
        case (a)
            7'h01, 7'h02, 7'h03, 7'h04, 7'h05, 7'h06: b = 8'hFF;
            7'h08: b = 8'h10;
            7'h09: b = 8'hAC;
            7'h0A: b = 8'h01;
            7'h0D: b = 8'h8B;
            7'h12: b = 8'h01;
            7'h13: b = 8'h03;
            7'h14: b = 8'h80;
            7'h15: b = 8'h30;
            7'h16: b = 8'h1B;
            7'h18: b = 8'h0A;
            7'h36: b = 8'h02;
            7'h37: b = 8'h3A;
            7'h38: b = 8'h80;
            7'h3A: b = 8'h70;
            7'h3B: b = 8'h38;
            7'h3D: b = 8'h40;
            7'h7F: b = 8'h41;
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    always_ff @(posedge i_clk) begin
        if (i_sel == IMG_W'(IMG_1920_1080))
            r_data <= f_img_1920(i_addr);
        else
            r_data <= f_img_1280(i_addr);
    end

    assign o_data = r_data;

endmodule

// File: rtl/edid_update_ctrl.sv
// Copies the selected EDID image from an external registered ROM into a shadow RAM and serves I2C
// reads from it, holding HPD low around every update. Optional macro: EDID_CHECKSUM_FIX_EN.
module edid_update_ctrl
    import edid_pkg::*;
#(
    parameter int HPD_LOW_CYCLES = 1000000,
    parameter int IMG_W          = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IMG_W-1:0] imageSel,
    input  logic             reload,
    output logic [IMG_W-1:0] romSel,
    output logic [6:0]       romAddr,
    input  logic [7:0]       romData,
    input  logic [7:0]       addr,
    output logic [7:0]       dataOut,
    output logic             hpd,
    output logic             busy,
    output logic             chkErr
);

    localparam int                CNT_W     = $clog2(HPD_LOW_CYCLES + 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HPD_LOW_CYCLES - 1);

    edid_state_t      r_state;
    logic [IMG_W-1:0] r_cur_sel;
    logic [IMG_W-1:0] r_rom_sel;
    logic [6:0]       r_rom_addr;
    logic [7:0]       r_cpy_cnt;
    logic [7:0]       r_sum;
    logic [CNT_W-1:0] r_cnt;
    logic             r_hpd;
    logic             r_busy;
    logic [7:0]       r_dout;
    logic [7:0]       r_ram [EDID_LEN];
`ifndef EDID_CHECKSUM_FIX_EN
    logic [7:0]       r_b127;
    logic             r_chk_err;
`endif

    logic       w_req;
    logic       w_hold_done;
    logic [7:0] w_chk;
    logic [6:0] w_cpy_idx;
    logic       w_cpy_wr;
    logic       w_ram_we;
    logic [6:0] w_ram_waddr;
    logic [7:0] w_ram_wdata;

    assign w_req       = reload | (imageSel != r_cur_sel);
    assign w_hold_done = (r_cnt >= HOLD_LAST);
    assign w_chk       = 8'h00 - r_sum;
    // Copy cycle n carries the ROM byte requested in cycle n-1.
    assign w_cpy_idx   = r_cpy_cnt[6:0] - 7'd1;
    assign w_cpy_wr    = (r_state == COPY) && (r_cpy_cnt != 8'd0);

    always_comb begin
        w_ram_we    = w_cpy_wr;
        w_ram_waddr = w_cpy_idx;
        w_ram_wdata = romData;
`ifdef EDID_CHECKSUM_FIX_EN
        if (r_state == FINISH) begin
            w_ram_we    = 1'b1;
            w_ram_waddr = 7'd127;
            w_ram_wdata = w_chk;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= DROP;
            r_cur_sel  <= '0;
            r_rom_sel  <= '0;
            r_rom_addr <= 7'd0;
            r_cpy_cnt  <= 8'd0;
            r_sum      <= 8'd0;
            r_cnt      <= '0;
            r_hpd      <= 1'b0;
            r_busy     <= 1'b1;
`ifndef EDID_CHECKSUM_FIX_EN
            r_chk_err  <= 1'b0;
`endif
        end else begin
            // Hold timer runs from DROP onward so copy time counts toward the HPD-low window.
            if (!w_hold_done)
                r_cnt <= r_cnt + CNT_W'(1);
            case (r_state)
                DROP: begin
                    r_rom_sel  <= imageSel;
                    r_cur_sel  <= imageSel;
                    r_cnt      <= '0;
                    r_rom_addr <= 7'd0;
                    r_cpy_cnt  <= 8'd0;
                    r_sum      <= 8'd0;
                    r_state    <= COPY;
                end
                COPY: begin
                    if (w_req) begin
                        r_state <= DROP;
                    end else begin
                        r_cpy_cnt <= r_cpy_cnt + 8'd1;
                        if (w_cpy_wr && (w_cpy_idx != 7'd127))
                            r_sum <= r_sum + romData;
`ifndef EDID_CHECKSUM_FIX_EN
                        if (r_cpy_cnt == 8'd128)
                            r_b127 <= romData;
`endif
                        if (r_cpy_cnt < 8'd127)
                            r_rom_addr <= r_rom_addr + 7'd1;
                        if (r_cpy_cnt == 8'd128)
                            r_state <= FINISH;
                    end
                end
                FINISH: begin
`ifndef EDID_CHECKSUM_FIX_EN
                    r_chk_err <= (r_b127 != w_chk);
`endif
                    if (w_req) begin
                        r_state <= DROP;
                    end else if (w_hold_done) begin
                        r_state <= READY;
                        r_hpd   <= 1'b1;
                        r_busy  <= 1'b0;
                    end else begin
                        r_state <= HOLD;
                    end
                end
                HOLD: begin
                    if (w_req) begin
                        r_state <= DROP;
                    end else if (w_hold_done) begin
                        r_state <= READY;
                        r_hpd   <= 1'b1;
                        r_busy  <= 1'b0;
                    end
                end
                READY: begin
                    if (w_req) begin
                        r_state <= DROP;
                        r_hpd   <= 1'b0;
                        r_busy  <= 1'b1;
                    end
                end
                default: r_state <= DROP;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_ram_we)
            r_ram[w_ram_waddr] <= w_ram_wdata;
    end

    // Busy overrides everything so a half-written image is never visible on the bus.
    always_ff @(posedge clk) begin
        if (rst)
            r_dout <= RD_OOR;
        else if (r_busy)
            r_dout <= RD_BUSY;
        else if (addr[7])
            r_dout <= RD_OOR;
        else
            r_dout <= r_ram[addr[6:0]];
    end

    assign romSel  = r_rom_sel;
    assign romAddr = r_rom_addr;
    assign dataOut = r_dout;
    assign hpd     = r_hpd;
    assign busy    = r_busy;
`ifdef EDID_CHECKSUM_FIX_EN
    assign chkErr  = 1'b0;
`else
    assign chkErr  = r_chk_err;
`endif

endmodule
